cpu_seq: RTL

//  Parametrised multi-cycle instruction sequencer for the 8-register datapath. Cycles FETCH -> EXEC -> PCINC.

---
 rtl/cpu_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle instruction sequencer (FETCH -> EXEC -> PCINC) for the
// 8-register datapath. It decodes the latched instruction into register write
// strobes, bus enables, the ALU op, the steering word and the immediate. It also
// handles memory wait states, a wait timeout, an illegal-opcode trap and halt.
// Optional feature: define CPU_SEQ_STACK_EN to enable PUSH/POP with r7 as SP.
// When the macro is undefined, both stack opcodes trap as illegal.
module cpu_seq #(
  parameter int DATA_W   = 16,
  parameter int CTL_W    = 13,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       insn_in,
  input  logic              mem_ready,
  input  logic              halt_req,
  output logic [7:0]        write_en,
  output logic [23:0]       output_en,
  output logic              data_write_en,
  output logic [2:0]        alu_op,
  output logic [CTL_W-1:0]  ctl_out,
  output logic [DATA_W-1:0] immediate,
  output logic              mem_req,
  output logic              halted,
  output logic              trap,
  output logic [1:0]        trap_cause
);

`ifdef CPU_SEQ_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_EXEC2 = 3'd2,
    ST_PCINC = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t      state_r, state_n;
  logic [15:0] insn_r;
  logic [7:0]  wcnt_r;
  logic        trap_r;
  logic [1:0]  trap_cause_r;
  logic        pc_wr_r;      // EXEC of the current instruction wrote r0 (PC)
  logic        halt_pend_r;  // halt request seen, honoured at the next boundary

  logic [7:0]        dec_we_s;
  logic [23:0]       dec_oe_s;
  logic              dec_dwe_s;
  logic [2:0]        dec_alu_s;
  logic [12:0]       dec_ctl_s;
  logic [DATA_W-1:0] dec_imm_s;
  logic              dec_mreq_s;
  logic              dec_halted_s;
  logic              timeout_s;
  logic              ill_trap_s;

  // One-hot register strobe for register index r.
  function automatic logic [7:0] reg_onehot(input logic [2:0] r);
    return 8'h01 << r;
  endfunction

  // Bus enable for register r driving bus b (0 = A, 1 = B, 2 = C).
  function automatic logic [23:0] bus_sel(input logic [2:0] r, input logic [1:0] b);
    logic [4:0] pos;
    pos = ({2'b00, r} * 5'd3) + {3'b000, b};
    return 24'h000001 << pos;
  endfunction

  // Instruction fields.
  logic [4:0]        op5_s;
  logic [2:0]        rd_s, ra_s, rb_s, rhi_s;
  logic [7:0]        c_s;
  logic [DATA_W-1:0] sx_s;
  logic              is_ld_s, is_st_s, is_push_s, is_pop_s, illegal_s, wait_hit_s;

  assign op5_s      = insn_r[15:11];
  assign rhi_s      = insn_r[13:11];
  assign rd_s       = insn_r[10:8];
  assign ra_s       = insn_r[7:5];
  assign rb_s       = insn_r[4:2];
  assign c_s        = insn_r[7:0];
  assign sx_s       = {{(DATA_W-8){c_s[7]}}, c_s};
  assign is_ld_s    = (insn_r[15:14] == 2'b11);
  assign is_st_s    = (insn_r[15:14] == 2'b10);
  assign is_push_s  = STACK_EN && (op5_s == 5'b01101);
  assign is_pop_s   = STACK_EN && (op5_s == 5'b01110);
  assign illegal_s  = (op5_s == 5'b01100) || (op5_s == 5'b01111) ||
                      (!STACK_EN && ((op5_s == 5'b01101) || (op5_s == 5'b01110)));
  assign wait_hit_s = (wcnt_r == WAIT_LAST);

  // Output decode of the registered state and instruction.
  always_comb begin
    dec_we_s     = 8'h00;
    dec_oe_s     = 24'h000000;
    dec_dwe_s    = 1'b0;
    dec_alu_s    = 3'b000;
    dec_ctl_s    = 13'h000;
    dec_imm_s    = {DATA_W{1'b0}};
    dec_mreq_s   = 1'b0;
    dec_halted_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        dec_mreq_s = 1'b1;
        dec_oe_s   = 24'h000001;
        dec_ctl_s  = 13'h090;
      end
      ST_EXEC: begin
        if (is_ld_s) begin
          dec_mreq_s = 1'b1;
          dec_we_s   = reg_onehot(rhi_s) & {8{mem_ready}};
          dec_oe_s   = bus_sel(rd_s, 2'd0);
          dec_alu_s  = 3'b101;
          dec_ctl_s  = 13'h055;
          dec_imm_s  = sx_s;
        end else if (is_st_s) begin
          dec_mreq_s = 1'b1;
          dec_dwe_s  = mem_ready;
          dec_oe_s   = bus_sel(rhi_s, 2'd0) | bus_sel(rd_s, 2'd1);
          dec_alu_s  = 3'b101;
          dec_ctl_s  = 13'h145;
          dec_imm_s  = sx_s;
        end else begin
          case (op5_s)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100: begin
              // Register-immediate ALU ops: R on bus A, result back to R.
              dec_we_s  = reg_onehot(rd_s);
              dec_oe_s  = bus_sel(rd_s, 2'd0);
              dec_ctl_s = 13'h025;
              case (op5_s)
                5'b00000: begin dec_alu_s = 3'b101; dec_imm_s = sx_s; end
                5'b00001: begin dec_alu_s = 3'b000; dec_imm_s = {DATA_W{1'b1}}; dec_imm_s[7:0]  = c_s; end
                5'b00010: begin dec_alu_s = 3'b000; dec_imm_s = {DATA_W{1'b1}}; dec_imm_s[15:8] = c_s; end
                5'b00011: begin dec_alu_s = 3'b001; dec_imm_s[7:0]  = c_s; end
                5'b00100: begin dec_alu_s = 3'b001; dec_imm_s[15:8] = c_s; end
                default:  begin dec_alu_s = 3'b000; end
              endcase
            end
            5'b00101, 5'b00110: begin
              dec_we_s       = reg_onehot(rd_s);
              dec_oe_s       = bus_sel(rd_s, 2'd2);
              dec_imm_s[7:0] = c_s;
              dec_ctl_s      = (op5_s == 5'b00101) ? 13'h1200 : 13'h0C00;
            end
            5'b00111: begin
              dec_we_s  = 8'h01;
              dec_oe_s  = bus_sel(3'd0, 2'd0) | bus_sel(rd_s, 2'd2);
              dec_imm_s = sx_s;
              dec_alu_s = 3'b110;
              dec_ctl_s = 13'h02D;
            end
            5'b01000: begin
              dec_we_s  = reg_onehot(rd_s);
              dec_oe_s  = bus_sel(ra_s, 2'd0);
              dec_alu_s = 3'b010;
              dec_ctl_s = 13'h021;
            end
            5'b01001, 5'b01010, 5'b01011: begin
              dec_we_s  = reg_onehot(rd_s);
              dec_oe_s  = bus_sel(ra_s, 2'd0) | bus_sel(rb_s, 2'd1);
              dec_ctl_s = 13'h023;
              case (op5_s)
                5'b01001: dec_alu_s = 3'b101;
                5'b01010: dec_alu_s = 3'b000;
                default:  dec_alu_s = 3'b001;
              endcase
            end
            5'b01101: begin
              // PUSH, first half: SP <= SP - 1.
              if (is_push_s) begin
                dec_we_s  = reg_onehot(3'd7);
                dec_oe_s  = bus_sel(3'd7, 2'd0);
                dec_imm_s = {DATA_W{1'b1}};
                dec_alu_s = 3'b101;
                dec_ctl_s = 13'h025;
              end else begin
                dec_we_s = 8'h00;
              end
            end
            5'b01110: begin
              // POP, first half: R <= [SP].
              if (is_pop_s) begin
                dec_mreq_s = 1'b1;
                dec_we_s   = reg_onehot(rd_s) & {8{mem_ready}};
                dec_oe_s   = bus_sel(3'd7, 2'd0);
                dec_alu_s  = 3'b101;
                dec_ctl_s  = 13'h055;
              end else begin
                dec_we_s = 8'h00;
              end
            end
            default: begin
              dec_we_s = 8'h00;  // illegal opcodes drive no strobes
            end
          endcase
        end
      end
      ST_EXEC2: begin
        if (is_push_s) begin
          dec_mreq_s = 1'b1;
          dec_dwe_s  = mem_ready;
          dec_oe_s   = bus_sel(3'd7, 2'd0) | bus_sel(rd_s, 2'd1);
          dec_alu_s  = 3'b101;
          dec_ctl_s  = 13'h145;
        end else if (is_pop_s) begin
          dec_we_s     = reg_onehot(3'd7);
          dec_oe_s     = bus_sel(3'd7, 2'd0);
          dec_imm_s[0] = 1'b1;
          dec_alu_s    = 3'b101;
          dec_ctl_s    = 13'h025;
        end else begin
          dec_we_s = 8'h00;
        end
      end
      ST_PCINC: begin
        dec_we_s     = 8'h01;
        dec_oe_s     = 24'h000001;
        dec_alu_s    = 3'b101;
        dec_ctl_s    = 13'h025;
        dec_imm_s[0] = !pc_wr_r;  // PC already redirected: add 0
      end
      ST_HALT: begin
        dec_halted_s = 1'b1;
      end
      default: begin
        dec_halted_s = 1'b0;
      end
    endcase
  end

  // Next-state logic, including memory waits, timeout and illegal trap.
  always_comb begin
    state_n    = state_r;
    timeout_s  = 1'b0;
    ill_trap_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) begin
          state_n = ST_EXEC;
        end else if (wait_hit_s) begin
          timeout_s = 1'b1;
          state_n   = ST_HALT;
        end else begin
          state_n = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (is_ld_s || is_st_s || is_pop_s) begin
          if (mem_ready) begin
            state_n = is_pop_s ? ST_EXEC2 : ST_PCINC;
          end else if (wait_hit_s) begin
            timeout_s = 1'b1;
            state_n   = ST_HALT;
          end else begin
            state_n = ST_EXEC;
          end
        end else if (is_push_s) begin
          state_n = ST_EXEC2;
        end else begin
          state_n    = ST_PCINC;
          ill_trap_s = illegal_s;
        end
      end
      ST_EXEC2: begin
        if (is_push_s) begin
          if (mem_ready) begin
            state_n = ST_PCINC;
          end else if (wait_hit_s) begin
            timeout_s = 1'b1;
            state_n   = ST_HALT;
          end else begin
            state_n = ST_EXEC2;
          end
        end else begin
          state_n = ST_PCINC;
        end
      end
      ST_PCINC: begin
        if (halt_req || halt_pend_r) begin
          state_n = ST_HALT;
        end else begin
          state_n = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_n = ST_HALT;
      end
      default: begin
        state_n = ST_FETCH;
      end
    endcase
  end

  // State, instruction, wait counter and trap registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_FETCH;
      insn_r       <= 16'h0000;
      wcnt_r       <= 8'h00;
      trap_r       <= 1'b0;
      trap_cause_r <= 2'b00;
      pc_wr_r      <= 1'b0;
      halt_pend_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      halt_pend_r <= halt_pend_r | halt_req;
      if ((state_r == ST_FETCH) && mem_ready) begin
        insn_r <= insn_in;
      end
      if (state_n != state_r) begin
        wcnt_r <= 8'h00;
      end else if (dec_mreq_s && !mem_ready) begin
        wcnt_r <= wcnt_r + 8'd1;
      end
      trap_r <= timeout_s | ill_trap_s;
      if (timeout_s) begin
        trap_cause_r <= 2'b10;
      end else if (ill_trap_s) begin
        trap_cause_r <= 2'b01;
      end
      if (state_r == ST_FETCH) begin
        pc_wr_r <= 1'b0;
      end else if (((state_r == ST_EXEC) || (state_r == ST_EXEC2)) && dec_we_s[0]) begin
        pc_wr_r <= 1'b1;
      end
    end
  end

  // Drive outputs; reset forces them low at once, even mid-access.
  always_comb begin
    if (reset) begin
      write_en      = 8'h00;
      output_en     = 24'h000000;
      data_write_en = 1'b0;
      alu_op        = 3'b000;
      ctl_out       = {CTL_W{1'b0}};
      immediate     = {DATA_W{1'b0}};
      mem_req       = 1'b0;
      halted        = 1'b0;
    end else begin
      write_en      = dec_we_s;
      output_en     = dec_oe_s;
      data_write_en = dec_dwe_s;
      alu_op        = dec_alu_s;
      ctl_out       = CTL_W'(dec_ctl_s);
      immediate     = dec_imm_s;
      mem_req       = dec_mreq_s;
      halted        = dec_halted_s;
    end
  end

  assign trap       = trap_r;
  assign trap_cause = trap_cause_r;

endmodule
